// File: rtl/mem_access_unit.sv
// Shared instruction/data memory port: one req/ready bus transaction per request.
// Owns IR, old PC and MDR; raises stall until the access completes.
//
// Ports:
//   clk, reset (async, active-low)
//   pc, alu_result, write_data   - fetch address, data address, store data
//   IRWrite, AddrSrc, MemWrite   - request decode from the main decoder
//   mem_req/we/addr/wdata        - bus request side (held until mem_ready)
//   mem_ready, mem_rdata         - bus completion side (sampled only in WAIT)
//   instr, old_pc, read_data     - IR, PC of IR, MDR
//   stall, bus_err               - core hold, sticky error
module mem_access_unit #(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                MAX_WAIT  = 255,
    parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(32'h13)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] alu_result,
    input  logic [DATA_W-1:0] write_data,
    input  logic              IRWrite,
    input  logic              AddrSrc,
    input  logic              MemWrite,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] old_pc,
    output logic [DATA_W-1:0] read_data,
    output logic              stall,
    output logic              bus_err
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] { S_IDLE, S_WAIT, S_DONE } state_t;
    typedef enum logic [1:0] { K_FETCH, K_LOAD, K_STORE } kind_t;

    state_t            state_q, state_d;
    kind_t             kind_q, kind_d;
    kind_t             req_kind;
    logic              req;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0] old_pc_q, old_pc_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    assign req      = IRWrite | AddrSrc;
    assign req_kind = IRWrite  ? K_FETCH :
                      MemWrite ? K_STORE : K_LOAD;

    // reset term keeps stall low while the core is held in reset
    assign stall     = reset & req & (state_q != S_DONE);
    assign mem_req   = (state_q == S_WAIT);
    assign mem_we    = (state_q == S_WAIT) & we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign instr     = instr_q;
    assign old_pc    = old_pc_q;
    assign read_data = rdata_q;
    assign bus_err   = err_q;

    always_comb begin
        state_d  = state_q;
        kind_d   = kind_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        instr_d  = instr_q;
        old_pc_d = old_pc_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (req_kind != K_FETCH && alu_result[1:0] != 2'b00) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        addr_d  = (req_kind == K_FETCH) ? pc : alu_result;
                        we_d    = (req_kind == K_STORE);
                        wdata_d = write_data;
                        kind_d  = req_kind;
                        cnt_d   = '0;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (mem_ready) begin
                    if (kind_q == K_FETCH) begin
                        instr_d  = mem_rdata;
                        old_pc_d = addr_q;
                    end else if (kind_q == K_LOAD) begin
                        rdata_d = mem_rdata;
                    end
                    state_d = S_DONE;
                end else if (cnt_q == CNT_W'(MAX_WAIT - 1)) begin
                    err_d = 1'b1;
                    if (kind_q == K_FETCH) begin
                        instr_d  = NOP_INSTR;
                        old_pc_d = addr_q;
                    end
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                we_d    = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            kind_q   <= K_FETCH;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            instr_q  <= NOP_INSTR;
            old_pc_q <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            kind_q   <= kind_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            instr_q  <= instr_d;
            old_pc_q <= old_pc_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: scoreboard of expected bus transactions
// plus a small model of IR / old PC / MDR / bus_err.
module tb_mem_access_unit;

    localparam int MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc, alu_result, write_data;
    logic        IRWrite, AddrSrc, MemWrite;
    logic        mem_req, mem_we, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [31:0] instr, old_pc, read_data;
    logic        stall, bus_err;

    mem_access_unit #(
        .ADDR_W(32), .DATA_W(32), .MAX_WAIT(MAX_WAIT), .NOP_INSTR(32'h13)
    ) dut (
        .clk(clk), .reset(reset), .pc(pc), .alu_result(alu_result),
        .write_data(write_data), .IRWrite(IRWrite), .AddrSrc(AddrSrc),
        .MemWrite(MemWrite), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .instr(instr), .old_pc(old_pc),
        .read_data(read_data), .stall(stall), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } bus_t;

    bus_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   tx = 0;

    logic [31:0] exp_instr, exp_old_pc, exp_rd;
    logic        exp_err;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset && mem_req && mem_ready) begin
            tx++;
            if (sb.size() == 0) begin
                chk("sb_unexpected", 1, 0);
            end else begin
                bus_t e;
                e = sb.pop_front();
                chk("bus_we", mem_we, e.we);
                chk("bus_addr", mem_addr, e.addr);
                chk("bus_wdata", mem_wdata, e.wdata);
            end
        end
    end

    task automatic check_model(input string tag);
        chk({tag, "_instr"}, instr, exp_instr);
        chk({tag, "_old_pc"}, old_pc, exp_old_pc);
        chk({tag, "_rd"}, read_data, exp_rd);
        chk({tag, "_err"}, bus_err, exp_err);
    endtask

    task automatic access(input string tag, input logic irw, as_, mw,
                          input logic [31:0] a, wd, input int waits,
                          input logic [31:0] rd);
        logic misal, tmo, fin;
        int   st, rq, wc;
        misal = !irw && (a[1:0] != 2'b00);
        tmo   = (waits >= MAX_WAIT);
        @(posedge clk); #1;
        IRWrite = irw; AddrSrc = as_; MemWrite = mw;
        if (irw) pc = a; else alu_result = a;
        write_data = wd;
        mem_ready = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
        if (!misal && !tmo)
            sb.push_back('{we: !irw && mw, addr: a, wdata: wd});
        st = 0; rq = 0; wc = 0; fin = 1'b0;
        for (int n = 0; n < 60 && !fin; n++) begin
            @(negedge clk);
            if (mem_req) rq++;
            if (stall) st++; else fin = 1'b1;
            if (!fin) begin
                @(posedge clk); #1;
                if (mem_req) begin
                    mem_ready = (wc == waits);
                    mem_rdata = mem_ready ? rd : $urandom;
                    wc++;
                end else begin
                    mem_ready = 1'($urandom_range(0, 1));
                    mem_rdata = $urandom;
                end
            end
        end
        chk({tag, "_done_seen"}, fin, 1);
        chk({tag, "_req_low_done"}, mem_req, 0);
        if (misal) begin
            exp_err = 1'b1;
            chk({tag, "_stall_cyc"}, st, 1);
            chk({tag, "_req_cyc"}, rq, 0);
        end else if (tmo) begin
            exp_err = 1'b1;
            if (irw) begin
                exp_instr  = 32'h13;
                exp_old_pc = a;
            end
            chk({tag, "_stall_cyc"}, st, MAX_WAIT + 1);
            chk({tag, "_req_cyc"}, rq, MAX_WAIT);
        end else begin
            if (irw) begin
                exp_instr  = rd;
                exp_old_pc = a;
            end else if (!mw) begin
                exp_rd = rd;
            end
            chk({tag, "_stall_cyc"}, st, waits + 2);
            chk({tag, "_req_cyc"}, rq, waits + 1);
        end
        check_model(tag);
    endtask

    task automatic model_reset();
        exp_instr  = 32'h13;
        exp_old_pc = 32'h0;
        exp_rd     = 32'h0;
        exp_err    = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        pc = '0; alu_result = '0; write_data = '0;
        IRWrite = 1'b1; AddrSrc = 1'b0; MemWrite = 1'b0;
        mem_ready = 1'b0; mem_rdata = '0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req", mem_req, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_stall", stall, 0);
        check_model("rst");
        @(posedge clk); #1;
        reset = 1'b1; IRWrite = 1'b0;

        access("fetch0", 1, 0, 0, 32'h40, 32'h0, 0, 32'h0050_0093);
        alu_result = 32'h302;
        access("prio", 1, 1, 1, 32'h3C, 32'h55, 0, 32'h0000_0513);
        access("load3", 0, 1, 0, 32'h100, 32'h0, 3, 32'hDEAD_BEEF);
        access("store", 0, 1, 1, 32'h204, 32'h1234, 2, 32'hFFFF_FFFF);
        access("tmo", 1, 0, 0, 32'h80, 32'h0, 1000, 32'h0);

        @(posedge clk); #1;
        IRWrite = 1'b1; AddrSrc = 1'b0; pc = 32'h60; mem_ready = 1'b0;
        @(posedge clk); #1;
        chk("rstw_in_wait", mem_req, 1);
        #2 reset = 1'b0;
        #1;
        model_reset();
        chk("rstw_req", mem_req, 0);
        chk("rstw_stall", stall, 0);
        check_model("rstw");
        @(posedge clk); #1;
        reset = 1'b1; IRWrite = 1'b0;

        access("refetch", 1, 0, 0, 32'h44, 32'h0, 1, 32'h0010_0113);
        access("misal", 0, 1, 0, 32'h102, 32'h0, 0, 32'h0);
        access("b2b_st", 0, 1, 1, 32'h208, 32'hCAFE, 0, 32'h0);
        access("b2b_f", 1, 0, 0, 32'h48, 32'h0, 1, 32'h0020_8093);

        @(posedge clk); #1;
        IRWrite = 1'b0; AddrSrc = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("idle_req", mem_req, 0);
        chk("sb_drained", sb.size(), 0);
        chk("tx_count", tx, 7);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
